// File: rtl/parity_frame_tx.sv
// parity_frame_tx
// Transmit end of the sensor parity link. A payload is accepted through a
// valid/ready handshake and encoded as an even-parity word {parity, payload}.
// The word is then shifted out serially: start bit (0), payload LSB first,
// parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles.
//
// Handshake: a payload transfers on a rising edge where tx_valid and tx_ready
// are both high. tx_ready is high only in IDLE. The source may hold tx_valid
// high at any time; while tx_ready is low the request is simply not taken,
// and nothing is queued.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tx_data    payload to send (DATA_W bits)
//   tx_valid   payload valid
//   tx_ready   block can accept a payload (IDLE)
//   tx_serial  registered serial line, idles high
//   tx_busy    frame in progress (any state other than IDLE)
//   frame_word last accepted encoded word {parity, payload}
//   frame_done one-cycle pulse in the first IDLE cycle after STOP
//   dbg_state  current FSM state, for debug and checkers
module parity_frame_tx #(
    parameter int DATA_W       = 5,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic [DATA_W:0]   frame_word,
    output logic              frame_done,
    output logic [2:0]        dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              parity_bit;

    logic              bit_end;
    logic              accept;
    logic              in_parity;
    logic [DATA_W-1:0] shift_next;

    assign tx_ready   = (state == IDLE);
    assign dbg_state  = state;
    assign accept     = tx_valid && tx_ready;
    assign in_parity  = ^tx_data;
    assign bit_end    = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign shift_next = shift >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            frame_word <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Accepting here includes the frame_done cycle, so frames
                    // can run back to back with no idle bits between them.
                    if (accept) begin
                        shift      <= tx_data;
                        parity_bit <= in_parity;
                        frame_word <= {in_parity, tx_data};
                        tx_serial  <= 1'b0;
                        tx_busy    <= 1'b1;
                        clk_cnt    <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_cnt   <= '0;
                        tx_serial <= shift[0];
                        state     <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BW'(DATA_W - 1)) begin
                            tx_serial <= parity_bit;
                            state     <= PARITY;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift     <= shift_next;
                            tx_serial <= shift_next[0];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt    <= '0;
                        tx_serial  <= 1'b1;
                        tx_busy    <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    clk_cnt   <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: table of payloads with expected encoded words,
// hand sequences for hold-off/back-to-back and mid-frame reset, and random
// payloads. A monitor samples tx_serial mid-bit and compares each received
// frame with the frame pushed to exp_q when the payload was driven.
module tb_parity_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [4:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic [5:0] frame_word;
    logic       frame_done;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    parity_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .frame_word (frame_word),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected serial frame, bit 0 sent first: start, payload LSB first, parity, stop.
    function automatic logic [7:0] mk_frame(input logic [4:0] d);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 5; i++) ones += int'(d[i]);
        p = ((ones % 2) == 1);
        return {1'b1, p, d, 1'b0};
    endfunction

    // monitor / scoreboard
    logic       busy_prev  = 1'b0;
    logic       mon_active = 1'b0;
    int         mon_k      = 0;
    logic [7:0] rx         = '0;
    logic [7:0] exp_frame;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            mon_k      = 0;
        end else begin
            if (!mon_active && tx_busy && !busy_prev) begin
                mon_active = 1'b1;
                mon_k      = 0;
            end
            if (frame_done && !(mon_active && mon_k == 32))
                chk("spurious_frame_done", 32'(frame_done), 32'd0);
            if (mon_active) begin
                if (mon_k < 32 && (mon_k % 4) == 2) rx[mon_k / 4] = tx_serial;
                if (mon_k == 32) begin
                    chk("frame_done_at_32", 32'(frame_done), 32'd1);
                    chk("start_bit", 32'(rx[0]), 32'd0);
                    chk("stop_bit", 32'(rx[7]), 32'd1);
                    chk("rx_even_parity", 32'(^rx[6:1]), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("exp_q_nonempty", 32'd0, 32'd1);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        chk("rx_frame", 32'(rx), 32'(exp_frame));
                    end
                    mon_active = 1'b0;
                end
                mon_k++;
            end
        end
        busy_prev = tx_busy;
    end

    // driver tasks
    task automatic send(input logic [4:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("send_ready_timeout", 32'd0, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back(mk_frame(d));
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!frame_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [4:0] data;
        logic [5:0] word;
    } vec_t;

    vec_t vecs[5];
    int   seen_done;

    initial begin
        vecs[0] = '{data: 5'b00001, word: 6'b100001};
        vecs[1] = '{data: 5'b00000, word: 6'b000000};
        vecs[2] = '{data: 5'b00011, word: 6'b000011};
        vecs[3] = '{data: 5'b11111, word: 6'b111111};
        vecs[4] = '{data: 5'b10110, word: 6'b110110};

        rst_n    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(tx_serial), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_word", 32'(frame_word), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // table: encoded word and its loopback parity
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data);
            chk("frame_word", 32'(frame_word), 32'(vecs[i].word));
            chk("busy_after_accept", 32'(tx_busy), 32'd1);
            chk("word_even_weight", 32'(^frame_word), 32'd0);
            wait_done();
            @(negedge clk);
        end

        // hold tx_valid through a frame; accepted only in the frame_done cycle
        tx_data  = 5'b00011;
        tx_valid = 1'b1;
        exp_q.push_back(mk_frame(5'b00011));
        @(negedge clk);
        tx_data = 5'b10101;
        for (int n = 0; n < 40 && !frame_done; n++) begin
            chk("hold_ready_low", 32'(tx_ready), 32'd0);
            chk("hold_word", 32'(frame_word), 32'h03);
            @(negedge clk);
        end
        chk("hold_done_seen", 32'(frame_done), 32'd1);
        chk("hold_ready_in_done", 32'(tx_ready), 32'd1);
        exp_q.push_back(mk_frame(5'b10101));
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_start_bit", 32'(tx_serial), 32'd0);
        chk("b2b_busy", 32'(tx_busy), 32'd1);
        chk("b2b_word", 32'(frame_word), 32'h35);
        wait_done();
        @(negedge clk);

        // reset during DATA
        send(5'b10110);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_serial", 32'(tx_serial), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (frame_done) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_word_cleared", 32'(frame_word), 32'd0);
        send(5'b01101);
        chk("fresh_word", 32'(frame_word), 32'h2d);
        wait_done();
        @(negedge clk);

        // random payloads, some back to back
        for (int i = 0; i < 200; i++) begin
            send(5'($urandom_range(0, 31)));
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
